// File: rtl/layer_scroll_sequencer.sv
// ---------------------------------------------------------------------------
// layer_scroll_sequencer
//
// Per-frame scroll scheduler for the parallax city layers. On each accepted
// frame strobe it visits layers 0..N_LAYERS-1 in turn. Each layer's cell phase
// advances once per step, and its building LFSR advances once per phase wrap.
// The number of steps is that layer's programmed speed. A single stepper is
// time-shared across all layers, so only one layer can change per cycle. The
// registered per-layer values are the line-start reload values that the
// scanline generator copies into its working LFSR and counters.
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset
//   frame_start  1-cycle frame strobe (vblank start)
//   upd_en       1 = layer state may change this cycle, 0 = stall the stepper
//   pause        1 = frame strobes are ignored while idle (scroll frozen)
//   speed        layer i speed at [i*SPEED_W +: SPEED_W]
//   clr_overrun  clears the sticky overrun flag
//   layer_lfsr   layer i reload LFSR at [i*LFSR_W +: LFSR_W]
//   layer_phase  layer i reload phase at [i*PHASE_W +: PHASE_W]
//   busy         high whenever the sequencer is not idle
//   frame_done   single-cycle pulse at the end of a frame update
//   overrun      sticky: a frame strobe arrived while busy
// ---------------------------------------------------------------------------
module layer_scroll_sequencer #(
    parameter int N_LAYERS         = 4,
    parameter int LFSR_W           = 9,
    parameter int TAP_A            = 8,
    parameter int TAP_B            = 4,
    parameter logic [LFSR_W-1:0] SEED = 9'h1FF,
    parameter int PHASE_W          = 3,
    parameter int SPEED_W          = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_start,
    input  logic                          upd_en,
    input  logic                          pause,
    input  logic [N_LAYERS*SPEED_W-1:0]   speed,
    input  logic                          clr_overrun,
    output logic [N_LAYERS*LFSR_W-1:0]    layer_lfsr,
    output logic [N_LAYERS*PHASE_W-1:0]   layer_phase,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overrun
);

    localparam int IDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_NEXT,
        S_DONE
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [IDX_W-1:0]     idx_reg;
    logic [SPEED_W-1:0]   rem_reg;
    logic                 overrun_reg;

    logic [LFSR_W-1:0]    lfsr_reg  [N_LAYERS];
    logic [PHASE_W-1:0]   phase_reg [N_LAYERS];
    logic [SPEED_W-1:0]   speed_arr [N_LAYERS];

    // Control strobes decoded from the current state
    logic                 start_en;
    logic                 load_en;
    logic                 step_en;
    logic                 next_en;
    logic                 last_layer;

    assign last_layer = (idx_reg == IDX_W'(N_LAYERS - 1));

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (frame_start && !pause) state_next = S_LOAD;
            S_LOAD: state_next = S_STEP;
            // A stalled step (upd_en low) holds in STEP with rem untouched.
            S_STEP: if (rem_reg == '0) state_next = S_NEXT;
            S_NEXT: state_next = last_layer ? S_DONE : S_LOAD;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs and datapath strobes
    // -----------------------------------------------------------------------
    always_comb begin
        busy       = 1'b0;
        frame_done = 1'b0;
        start_en   = 1'b0;
        load_en    = 1'b0;
        step_en    = 1'b0;
        next_en    = 1'b0;
        case (state_reg)
            S_IDLE: start_en = frame_start && !pause;
            S_LOAD: begin
                busy    = 1'b1;
                load_en = 1'b1;
            end
            S_STEP: begin
                busy    = 1'b1;
                step_en = (rem_reg != '0) && upd_en;
            end
            S_NEXT: begin
                busy    = 1'b1;
                next_en = !last_layer;
            end
            S_DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Sequencer datapath: layer index and remaining-step counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_reg <= '0;
            rem_reg <= '0;
        end else begin
            if (start_en) begin
                idx_reg <= '0;
            end else if (next_en) begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
            // Speed is sampled only at LOAD, so a speed change mid-frame
            // affects only layers not yet loaded.
            if (load_en) begin
                rem_reg <= speed_arr[idx_reg];
            end else if (step_en) begin
                rem_reg <= rem_reg - SPEED_W'(1);
            end
        end
    end

    // Sticky overrun: a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun_reg <= 1'b0;
        end else if (frame_start && busy) begin
            overrun_reg <= 1'b1;
        end else if (clr_overrun) begin
            overrun_reg <= 1'b0;
        end
    end

    assign overrun = overrun_reg;

    // -----------------------------------------------------------------------
    // Per-layer scroll state. Only the layer selected by idx may step.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_LAYERS; gi++) begin : g_layer
            logic step_here;

            assign speed_arr[gi] = speed[gi*SPEED_W +: SPEED_W];
            assign step_here     = step_en && (idx_reg == IDX_W'(gi));

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    lfsr_reg[gi]  <= SEED;
                    phase_reg[gi] <= '1;
                end else if (step_here) begin
                    phase_reg[gi] <= phase_reg[gi] + PHASE_W'(1);
                    // The building LFSR advances once per cell, i.e. when the
                    // phase wraps from all-ones back to zero.
                    if (phase_reg[gi] == '1) begin
                        lfsr_reg[gi] <= {lfsr_reg[gi][LFSR_W-2:0],
                                         lfsr_reg[gi][TAP_A] ^ lfsr_reg[gi][TAP_B]};
                    end
                end
            end

            assign layer_lfsr[gi*LFSR_W +: LFSR_W]    = lfsr_reg[gi];
            assign layer_phase[gi*PHASE_W +: PHASE_W] = phase_reg[gi];
        end
    endgenerate

endmodule
